// File: rtl/fifo_sc_prog_flags.sv
// Single-clock register-array FIFO with selectable FWFT/registered read, programmable
// almost-full/almost-empty thresholds, sticky error flags, synchronous flush and peak watermark.
`default_nettype none

module fifo_sc_prog_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   peak_depth,
  input  logic                  clr_stat
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wrptr_q, wrptr_d;
  logic [PW-1:0]         rdptr_q, rdptr_d;
  logic [PW-1:0]         depth_d;
  logic [PW-1:0]         peak_q, peak_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wenq, renq;

  // Flags come from registered pointers only; flush suppresses both accepts.
  assign depth        = wrptr_q - rdptr_q;
  assign empty        = (depth == '0);
  assign full         = (depth == PW'(DEPTH));
  assign almost_full  = (depth >= af_thresh);
  assign almost_empty = (depth <= ae_thresh);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign peak_depth   = peak_q;

  assign wenq = wen & ~full  & ~flush;
  assign renq = ren & ~empty & ~flush;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
    end else begin
      if (wenq) wrptr_d = wrptr_q + PW'(1);
      if (renq) rdptr_d = rdptr_q + PW'(1);
    end
    depth_d = wrptr_d - rdptr_d;
    peak_d  = clr_stat ? depth : ((depth_d > peak_q) ? depth_d : peak_q);
    // Set has priority over clear.
    ovf_d   = (ovf_q & ~clr_stat) | (wen & full  & ~flush);
    udf_d   = (udf_q & ~clr_stat) | (ren & empty & ~flush);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      peak_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      peak_q  <= peak_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wenq) mem_q[wrptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem_q[rdptr_q[ADDR_WIDTH-1:0]];
      assign rd_valid = 1'b0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rv_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= renq;
          if (renq) dout_q <= mem_q[rdptr_q[ADDR_WIDTH-1:0]];
        end
      end
      assign data_out = dout_q;
      assign rd_valid = rv_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_sc_prog_flags.sv
// Bench for fifo_sc_prog_flags: FWFT and registered-read instances share stimulus and are
// checked against a queue scoreboard, a constant vector table and hand-written corner sequences.
`default_nettype none

module tb_fifo_sc_prog_flags;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       flush = 1'b0, wen = 1'b0, ren = 1'b0, clr_stat = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [4:0] af_thresh = 5'd12, ae_thresh = 5'd3;

  logic [7:0] dout1, dout0;
  logic       rv1, rv0;
  logic [4:0] dep1, dep0, pk1, pk0;
  logic       emp1, ful1, af1, ae1, ovf1, udf1;
  logic       emp0, ful0, af0, ae0, ovf0, udf0;

  always #5 clk = ~clk;

  fifo_sc_prog_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(dout1), .rd_valid(rv1), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .depth(dep1), .empty(emp1), .full(ful1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(udf1), .peak_depth(pk1), .clr_stat(clr_stat));

  fifo_sc_prog_flags #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_reg (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wen(wen), .data_in(data_in), .ren(ren),
    .data_out(dout0), .rd_valid(rv0), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .depth(dep0), .empty(emp0), .full(ful0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(udf0), .peak_depth(pk0), .clr_stat(clr_stat));

  int n_chk = 0;
  int n_fail = 0;

  // Scoreboard / reference state
  logic [7:0] q[$];
  logic       m_ovf, m_udf, m_rv;
  logic [4:0] m_peak;
  logic [7:0] m_dout0;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       f;
    logic       c;
    logic [4:0] edep;
    logic       eemp;
    logic       eovf;
    logic       eudf;
  } vec_t;
  vec_t tab[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1: asserts reset asynchronously and checks before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_depth", dep1, 0);
    check("rst_empty", emp1, 1);
    check("rst_full", ful1, 0);
    check("rst_ovf", ovf1, 0);
    check("rst_udf", udf1, 0);
    check("rst_peak", pk1, 0);
    check("rst_rv1", rv1, 0);
    check("rst_rv0", rv0, 0);
    check("rst_dout0", dout0, 0);
    check("rst_depth0", dep0, 0);
    wen = 0; ren = 0; flush = 0; clr_stat = 0;
    q.delete();
    m_ovf = 0; m_udf = 0; m_rv = 0; m_peak = 0; m_dout0 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    logic       mfull, mempty, wq, rq;
    logic [4:0] pre;
    wen = w; data_in = d; ren = r; flush = f; clr_stat = c;
    pre    = 5'(q.size());
    mfull  = (q.size() == 16);
    mempty = (q.size() == 0);
    wq = w & ~mfull & ~f;
    rq = r & ~mempty & ~f;
    if (rq) check("fwft_dout", dout1, q[0]);
    @(posedge clk);
    #1;
    m_ovf = (m_ovf & ~c) | (w & mfull & ~f);
    m_udf = (m_udf & ~c) | (r & mempty & ~f);
    if (f) begin
      q.delete();
      m_rv = 0;
    end else begin
      m_rv = rq;
      if (rq) m_dout0 = q.pop_front();
      if (wq) q.push_back(d);
    end
    if (c) m_peak = pre;
    else if (5'(q.size()) > m_peak) m_peak = 5'(q.size());
    check("depth", dep1, q.size());
    check("empty", emp1, q.size() == 0);
    check("full", ful1, q.size() == 16);
    check("almost_full", af1, q.size() >= af_thresh);
    check("almost_empty", ae1, q.size() <= ae_thresh);
    check("overflow", ovf1, m_ovf);
    check("underflow", udf1, m_udf);
    check("peak_depth", pk1, m_peak);
    check("rv_fwft", rv1, 0);
    check("depth_reg", dep0, q.size());
    check("rd_valid", rv0, m_rv);
    check("dout_reg", dout0, m_dout0);
    wen = 0; ren = 0; flush = 0; clr_stat = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    tab[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1};
    tab[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0};
    tab[3] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
    tab[4] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tab[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1};
    tab[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
    tab[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};

    #3;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      step(tab[i].w, tab[i].d, tab[i].r, tab[i].f, tab[i].c);
      check("tab_depth", dep1, tab[i].edep);
      check("tab_empty", emp1, tab[i].eemp);
      check("tab_ovf", ovf1, tab[i].eovf);
      check("tab_udf", udf1, tab[i].eudf);
    end

    // Fill, overflow attempt, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0);
    check("t1_full", ful1, 1);
    check("t1_depth16", dep1, 16);
    step(1, 8'hAA, 0, 0, 0);
    check("t1_ovf", ovf1, 1);
    for (int i = 0; i < 16; i++) begin
      check("t1_order", dout1, 8'(i));
      step(0, 8'h00, 1, 0, 0);
    end
    check("t1_empty", emp1, 1);

    // Three fill-15 / drain-15 laps carry the pointers through several wraps
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 15; i++) step(1, 8'((lap << 4) + i + 8'h40), 0, 0, 0);
      check("t2_depth15", dep1, 15);
      for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
      check("t2_empty", emp1, 1);
    end

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    check("t3_full_rw_depth", dep1, 15);
    check("t3_full_rw_ovf", ovf1, 1);
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0, 0);
    step(1, 8'h99, 1, 0, 0);
    check("t3_empty_rw_depth", dep1, 1);
    check("t3_empty_rw_udf", udf1, 1);

    // Registered-read latency and hold
    do_reset();
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("t4_rv_high", rv0, 1);
    check("t4_dout", dout0, 8'h5A);
    step(0, 8'h00, 0, 0, 0);
    check("t4_rv_low", rv0, 0);
    check("t4_dout_hold", dout0, 8'h5A);

    // Thresholds and watermark
    step(0, 8'h00, 0, 1, 1);
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 8'(8'h10 + i), 0, 0, 0);
      if (i == 10) check("t5_af_11", af1, 0);
    end
    check("t5_af_12", af1, 1);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'h00, 1, 0, 0);
      if (i == 7) check("t5_ae_4", ae1, 0);
    end
    check("t5_ae_3", ae1, 1);
    check("t5_peak12", pk1, 12);
    check("t5_udf_set", udf1, 1);
    step(0, 8'h00, 0, 0, 1);
    check("t5_peak_clr", pk1, 3);
    check("t5_udf_clr", udf1, 0);

    // Flush beats write; then reset mid-burst
    for (int i = 0; i < 4; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    check("t6_depth7", dep1, 7);
    step(1, 8'h77, 0, 1, 0);
    check("t6_flush_depth", dep1, 0);
    check("t6_flush_empty", emp1, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 1, 0, 0);
    wen = 1; ren = 1; data_in = 8'h85;
    #2;
    do_reset();
    step(0, 8'h00, 1, 0, 0);
    check("t6_post_rst_udf", udf1, 1);

    // Threshold extremes
    af_thresh = 5'd0;
    #1;
    check("af_zero", af1, 1);
    ae_thresh = 5'd16;
    for (int i = 0; i < 16; i++) step(1, 8'(i + 8'h20), 0, 0, 0);
    check("ae_16_full", ae1, 1);
    check("ae_16_isfull", ful1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
